player_ctl: RTL

- Producer of the player position and facing inputs consumed by the player-sprite draw stage: player_xpos, player_ypos, direction.
- Reads synchronised-inside button inputs and updates a walk/jump/fall state machine once per frame.
- The frame tick is taken from the vblnk rising edge, so outputs change only during vertical blanking and never mid-frame.
- Sits between the input logic and the draw pipeline, clocked on the VGA pixel clock.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/btn_sync.sv | 24 ++
 rtl/player_ctl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/player definitions: player FSM states and default
// geometry/physics constants used by the controller and draw stages.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        JUMP,
        FALL
    } player_state_t;

    localparam logic [9:0] PLAYER_X_INIT    = 10'd10;
    localparam logic [9:0] PLAYER_Y_FLOOR   = 10'd292;
    localparam logic [9:0] PLAYER_Y_MIN     = 10'd0;
    localparam logic [9:0] PLAYER_X_MIN     = 10'd0;
    localparam logic [9:0] PLAYER_X_MAX     = 10'd958;
    localparam logic [9:0] PLAYER_WALK_STEP = 10'd2;
    localparam logic [4:0] PLAYER_JUMP_V0   = 5'd12;
    localparam logic [4:0] PLAYER_GRAVITY   = 5'd1;
    localparam logic [4:0] PLAYER_V_MAX     = 5'd15;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous button, plus a
// single-cycle pulse on the synchronised rising edge.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [2:0] sh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= {sh_q[1:0], async_in};
        end
    end

    assign sync_out = sh_q[1];
    assign rise     = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/player_ctl.sv
// Player position/facing controller: walk/jump/fall FSM stepped once
// per frame on the vblnk rising edge, so outputs only move in blanking.
module player_ctl
    import vga_pkg::*;
#(
    parameter logic [9:0] X_INIT    = PLAYER_X_INIT,
    parameter logic [9:0] Y_FLOOR   = PLAYER_Y_FLOOR,
    parameter logic [9:0] Y_MIN     = PLAYER_Y_MIN,
    parameter logic [9:0] X_MIN     = PLAYER_X_MIN,
    parameter logic [9:0] X_MAX     = PLAYER_X_MAX,
    parameter logic [9:0] WALK_STEP = PLAYER_WALK_STEP,
    parameter logic [4:0] JUMP_V0   = PLAYER_JUMP_V0,
    parameter logic [4:0] GRAVITY   = PLAYER_GRAVITY,
    parameter logic [4:0] V_MAX     = PLAYER_V_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] player_xpos,
    output logic [9:0] player_ypos,
    output logic       direction,
    output logic       airborne,
    output logic       frame_tick
);

    logic left_s, right_s, jump_s, jump_rise;

    btn_sync u_left (
        .clk      (clk),
        .rst      (rst),
        .async_in (btn_left),
        .sync_out (left_s),
        .rise     ()
    );

    btn_sync u_right (
        .clk      (clk),
        .rst      (rst),
        .async_in (btn_right),
        .sync_out (right_s),
        .rise     ()
    );

    btn_sync u_jump (
        .clk      (clk),
        .rst      (rst),
        .async_in (btn_jump),
        .sync_out (jump_s),
        .rise     (jump_rise)
    );

    player_state_t state_q, state_d;
    logic [9:0]    xpos_q, xpos_d;
    logic [9:0]    ypos_q, ypos_d;
    logic [4:0]    vel_q, vel_d;
    logic          dir_q, dir_d;
    logic          air_q, air_d;
    logic          jreq_q, jreq_d;
    logic          vblnk_q;
    logic          tick_q;

    logic [10:0]   x_add, x_lo, y_lim, y_fall;
    logic [5:0]    vel_sum;
    logic [4:0]    vel_up;
    player_state_t ground_st;
    logic          unused_jump_s;

    assign unused_jump_s = jump_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xpos_q  <= X_INIT;
            ypos_q  <= Y_FLOOR;
            vel_q   <= '0;
            dir_q   <= 1'b1;
            air_q   <= 1'b0;
            jreq_q  <= 1'b0;
            vblnk_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            vel_q   <= vel_d;
            dir_q   <= dir_d;
            air_q   <= air_d;
            jreq_q  <= jreq_d;
            vblnk_q <= vblnk;
            tick_q  <= vblnk & ~vblnk_q;
        end
    end

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        vel_d   = vel_q;
        dir_d   = dir_q;
        jreq_d  = jreq_q | jump_rise;

        x_add   = {1'b0, xpos_q} + {1'b0, WALK_STEP};
        x_lo    = {1'b0, X_MIN} + {1'b0, WALK_STEP};
        y_lim   = {1'b0, Y_MIN} + {6'd0, vel_q};
        vel_sum = {1'b0, vel_q} + {1'b0, GRAVITY};
        vel_up  = (vel_sum > {1'b0, V_MAX}) ? V_MAX : vel_sum[4:0];
        y_fall  = {1'b0, ypos_q} + {6'd0, vel_up};

        ground_st = (left_s ^ right_s) ? WALK : IDLE;

        if (tick_q) begin
            // Any pending request is either taken or, in the air, dropped.
            jreq_d = jump_rise;

            unique case (1'b1)
                right_s & ~left_s: begin
                    xpos_d = (x_add > {1'b0, X_MAX}) ? X_MAX : x_add[9:0];
                    dir_d  = 1'b1;
                end
                left_s & ~right_s: begin
                    xpos_d = ({1'b0, xpos_q} < x_lo) ? X_MIN
                                                     : xpos_q - WALK_STEP;
                    dir_d  = 1'b0;
                end
                default: ;
            endcase

            unique case (state_q)
                IDLE, WALK: begin
                    state_d = ground_st;
                    if (jreq_q) begin
                        state_d = JUMP;
                        vel_d   = JUMP_V0;
                    end
                end
                JUMP: begin
                    if ({1'b0, ypos_q} < y_lim) begin
                        ypos_d  = Y_MIN;
                        vel_d   = '0;
                        state_d = FALL;
                    end else begin
                        ypos_d = ypos_q - {5'd0, vel_q};
                        vel_d  = vel_q - GRAVITY;
                        if (vel_q <= GRAVITY) begin
                            vel_d   = '0;
                            state_d = FALL;
                        end
                    end
                end
                FALL: begin
                    vel_d = vel_up;
                    if (y_fall >= {1'b0, Y_FLOOR}) begin
                        ypos_d  = Y_FLOOR;
                        vel_d   = '0;
                        state_d = ground_st;
                    end else begin
                        ypos_d = y_fall[9:0];
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        air_d = (state_d == JUMP) || (state_d == FALL);
    end

    assign player_xpos = xpos_q;
    assign player_ypos = ypos_q;
    assign direction   = dir_q;
    assign airborne    = air_q;
    assign frame_tick  = tick_q;

endmodule
